padded_fmap_writer: RTL

Parametrised successor to the fused padding controller. It streams a feature map of C channels × W × H, packed LANES channels per word, into a line/feature buffer in raster order. Zero words fill a border of configurable width on all four sides. Unlike the fixed 16-lane, pad-of-1 controller, it has:
- runtime channel, width, height, pad and base-address configuration;
- a valid/ready input handshake;
- a per-row completion pulse;
- configuration error checking.

---
 rtl/padded_fmap_writer_if.sv | 39 +++
 rtl/padded_fmap_writer.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/padded_fmap_writer_if.sv
// ---------------------------------------------------------------------------
// padded_fmap_writer_if
//   Bundles the two data paths of the padded feature-map writer:
//     - input stream : in_valid / in_data from the producer, in_ready back
//     - buffer write : wr_en / wr_addr / wr_data towards the line buffer
//   Modports:
//     master : producer / buffer side (drives the input stream, observes
//              in_ready and the write bus)
//     slave  : the writer block itself
// ---------------------------------------------------------------------------
interface padded_fmap_writer_if #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 32
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output wr_en,
        output wr_addr,
        output wr_data
    );
endinterface

// File: rtl/padded_fmap_writer.sv
// ---------------------------------------------------------------------------
// padded_fmap_writer
//   Streams a C x W x H feature map (LANES channels packed per word) into a
//   buffer in raster order (row, pixel, word), surrounding it with a border
//   of P zero pixels on all four sides. Addresses run contiguously from
//   cfg_base, wrapping modulo 2^ADDR_W.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start           begin one frame (only looked at while idle)
//   cfg_c/w/h/pad   channel count, width, height, border width
//   cfg_base        address of the first write
//   bus (slave)     in_valid/in_data/in_ready input stream and
//                   wr_en/wr_addr/wr_data buffer write port
//   line_done       pulse with the last write of every padded row
//   busy            frame in progress
//   done            pulse the cycle after the final write
//   err_cfg         pulse when a start is rejected for a bad configuration
// ---------------------------------------------------------------------------
module padded_fmap_writer #(
    parameter int DATA_W  = 128,
    parameter int LANES   = 16,
    parameter int ADDR_W  = 32,
    parameter int MAX_PAD = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [15:0]         cfg_c,
    input  logic [15:0]         cfg_w,
    input  logic [15:0]         cfg_h,
    input  logic [1:0]          cfg_pad,
    input  logic [ADDR_W-1:0]   cfg_base,
    padded_fmap_writer_if.slave bus,
    output logic                line_done,
    output logic                busy,
    output logic                done,
    output logic                err_cfg
);

    localparam int          LANE_SH   = $clog2(LANES);
    localparam logic [15:0] LANE_MASK = 16'(LANES - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_TOP   = 3'd1,
        ST_LEFT  = 3'd2,
        ST_DATA  = 3'd3,
        ST_RIGHT = 3'd4,
        ST_BOT   = 3'd5,
        ST_FIN   = 3'd6
    } state_t;

    // A frame is legal when channels fill whole words, the map is non-empty
    // and the border fits the supported range.
    function automatic logic cfg_legal(input logic [15:0] c,
                                       input logic [15:0] w,
                                       input logic [15:0] h,
                                       input logic [1:0]  pad);
        logic ok;
        ok = (c != 16'd0) && ((c & LANE_MASK) == 16'd0) &&
             (w != 16'd0) && (h != 16'd0) && (int'(pad) <= MAX_PAD);
        return ok;
    endfunction

    // ------------------------------------------------------------------
    // Frame geometry derived from the live cfg inputs; captured at start
    // ------------------------------------------------------------------
    logic [15:0] cw_s;
    logic [16:0] pw_s;
    logic [31:0] row_words_s;
    logic [31:0] side_len_s;
    logic [31:0] data_len_s;
    logic [16:0] ph_last_s;
    logic [16:0] top_last_s;
    logic [16:0] data_last_s;
    logic        cfg_ok_s;

    assign cw_s        = cfg_c >> LANE_SH;
    assign pw_s        = {1'b0, cfg_w} + {14'd0, cfg_pad, 1'b0};
    assign row_words_s = 32'(pw_s) * 32'(cw_s);
    assign side_len_s  = 32'(cfg_pad) * 32'(cw_s);
    assign data_len_s  = 32'(cfg_w) * 32'(cw_s);
    // Row indices: 0..P-1 top border, P..P+H-1 data rows, then bottom border.
    assign ph_last_s   = {1'b0, cfg_h} + {14'd0, cfg_pad, 1'b0} - 17'd1;
    assign top_last_s  = {15'd0, cfg_pad} - 17'd1;
    assign data_last_s = {15'd0, cfg_pad} + {1'b0, cfg_h} - 17'd1;
    assign cfg_ok_s    = cfg_legal(cfg_c, cfg_w, cfg_h, cfg_pad);

    // ------------------------------------------------------------------
    // State and registers
    // ------------------------------------------------------------------
    state_t              state_r, state_nxt;
    logic [31:0]         seg_cnt_r, seg_nxt;
    logic [16:0]         row_cnt_r, row_nxt;
    logic [ADDR_W-1:0]   addr_cnt_r, addr_nxt;

    logic [31:0]         row_words_r;
    logic [31:0]         side_len_r;
    logic [31:0]         data_len_r;
    logic [16:0]         ph_last_r;
    logic [16:0]         top_last_r;
    logic [16:0]         data_last_r;
    logic                pad_zero_r;

    logic                wr_en_r;
    logic [ADDR_W-1:0]   wr_addr_r;
    logic [DATA_W-1:0]   wr_data_r;
    logic                line_done_r;
    logic                busy_r, busy_nxt;
    logic                done_r;
    logic                err_cfg_r;

    logic [31:0]         seg_len_s;
    logic                seg_end_s;
    logic                row_last_s;
    logic                wr_s;
    logic [ADDR_W-1:0]   wr_addr_s;
    logic [DATA_W-1:0]   wr_data_s;
    logic                ld_s;
    logic                done_s;
    logic                err_s;
    logic                latch_s;

    // Length of the segment the current state is walking through
    always_comb begin
        seg_len_s = 32'd1;
        case (state_r)
            ST_TOP, ST_BOT:    seg_len_s = row_words_r;
            ST_LEFT, ST_RIGHT: seg_len_s = side_len_r;
            ST_DATA:           seg_len_s = data_len_r;
            default:           seg_len_s = 32'd1;
        endcase
    end

    assign seg_end_s  = (seg_cnt_r == seg_len_s - 32'd1);
    assign row_last_s = (row_cnt_r == ph_last_r);

    // Next-state, counter and write-issue logic of the frame walker
    always_comb begin
        state_nxt = state_r;
        seg_nxt   = seg_cnt_r;
        row_nxt   = row_cnt_r;
        addr_nxt  = addr_cnt_r;
        busy_nxt  = busy_r;
        wr_s      = 1'b0;
        wr_addr_s = addr_cnt_r;
        wr_data_s = '0;
        ld_s      = 1'b0;
        done_s    = 1'b0;
        err_s     = 1'b0;
        latch_s   = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (cfg_ok_s) begin
                        latch_s  = 1'b1;
                        busy_nxt = 1'b1;
                        row_nxt  = 17'd0;
                        if (cfg_pad == 2'd0) begin
                            state_nxt = ST_DATA;
                            seg_nxt   = 32'd0;
                            addr_nxt  = cfg_base;
                        end else begin
                            // The first top-border word is issued on the
                            // start edge itself so it appears with busy.
                            // A padded row holds at least 3 words, so this
                            // can never be the end of a row.
                            state_nxt = ST_TOP;
                            wr_s      = 1'b1;
                            wr_addr_s = cfg_base;
                            seg_nxt   = 32'd1;
                            addr_nxt  = cfg_base + ADDR_W'(1);
                        end
                    end else begin
                        err_s = 1'b1;
                    end
                end else begin
                    state_nxt = ST_IDLE;
                end
            end

            ST_TOP: begin
                wr_s     = 1'b1;
                addr_nxt = addr_cnt_r + ADDR_W'(1);
                if (seg_end_s) begin
                    ld_s    = 1'b1;
                    seg_nxt = 32'd0;
                    row_nxt = row_cnt_r + 17'd1;
                    if (row_cnt_r == top_last_r) begin
                        state_nxt = ST_LEFT;
                    end else begin
                        state_nxt = ST_TOP;
                    end
                end else begin
                    seg_nxt = seg_cnt_r + 32'd1;
                end
            end

            ST_LEFT: begin
                wr_s     = 1'b1;
                addr_nxt = addr_cnt_r + ADDR_W'(1);
                if (seg_end_s) begin
                    seg_nxt   = 32'd0;
                    state_nxt = ST_DATA;
                end else begin
                    seg_nxt = seg_cnt_r + 32'd1;
                end
            end

            ST_DATA: begin
                if (bus.in_valid) begin
                    wr_s      = 1'b1;
                    wr_data_s = bus.in_data;
                    addr_nxt  = addr_cnt_r + ADDR_W'(1);
                    if (seg_end_s) begin
                        seg_nxt = 32'd0;
                        if (pad_zero_r) begin
                            // No border: the data row is the whole padded row.
                            ld_s    = 1'b1;
                            row_nxt = row_cnt_r + 17'd1;
                            if (row_last_s) begin
                                state_nxt = ST_FIN;
                            end else begin
                                state_nxt = ST_DATA;
                            end
                        end else begin
                            state_nxt = ST_RIGHT;
                        end
                    end else begin
                        seg_nxt = seg_cnt_r + 32'd1;
                    end
                end else begin
                    state_nxt = ST_DATA;
                end
            end

            ST_RIGHT: begin
                wr_s     = 1'b1;
                addr_nxt = addr_cnt_r + ADDR_W'(1);
                if (seg_end_s) begin
                    ld_s    = 1'b1;
                    seg_nxt = 32'd0;
                    row_nxt = row_cnt_r + 17'd1;
                    if (row_cnt_r == data_last_r) begin
                        state_nxt = ST_BOT;
                    end else begin
                        state_nxt = ST_LEFT;
                    end
                end else begin
                    seg_nxt = seg_cnt_r + 32'd1;
                end
            end

            ST_BOT: begin
                wr_s     = 1'b1;
                addr_nxt = addr_cnt_r + ADDR_W'(1);
                if (seg_end_s) begin
                    ld_s    = 1'b1;
                    seg_nxt = 32'd0;
                    row_nxt = row_cnt_r + 17'd1;
                    if (row_last_s) begin
                        state_nxt = ST_FIN;
                    end else begin
                        state_nxt = ST_BOT;
                    end
                end else begin
                    seg_nxt = seg_cnt_r + 32'd1;
                end
            end

            ST_FIN: begin
                done_s    = 1'b1;
                busy_nxt  = 1'b0;
                state_nxt = ST_IDLE;
            end

            default: begin
                state_nxt = ST_IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    // FSM state and walk counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            seg_cnt_r  <= 32'd0;
            row_cnt_r  <= 17'd0;
            addr_cnt_r <= '0;
        end else begin
            state_r    <= state_nxt;
            seg_cnt_r  <= seg_nxt;
            row_cnt_r  <= row_nxt;
            addr_cnt_r <= addr_nxt;
        end
    end

    // Frame geometry captured on an accepted start; held for the whole frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_words_r <= 32'd0;
            side_len_r  <= 32'd0;
            data_len_r  <= 32'd0;
            ph_last_r   <= 17'd0;
            top_last_r  <= 17'd0;
            data_last_r <= 17'd0;
            pad_zero_r  <= 1'b0;
        end else if (latch_s) begin
            row_words_r <= row_words_s;
            side_len_r  <= side_len_s;
            data_len_r  <= data_len_s;
            ph_last_r   <= ph_last_s;
            top_last_r  <= top_last_s;
            data_last_r <= data_last_s;
            pad_zero_r  <= (cfg_pad == 2'd0);
        end else begin
            row_words_r <= row_words_r;
            side_len_r  <= side_len_r;
            data_len_r  <= data_len_r;
            ph_last_r   <= ph_last_r;
            top_last_r  <= top_last_r;
            data_last_r <= data_last_r;
            pad_zero_r  <= pad_zero_r;
        end
    end

    // Registered write port and status pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_r     <= 1'b0;
            wr_addr_r   <= '0;
            wr_data_r   <= '0;
            line_done_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_cfg_r   <= 1'b0;
        end else begin
            wr_en_r     <= wr_s;
            line_done_r <= ld_s;
            busy_r      <= busy_nxt;
            done_r      <= done_s;
            err_cfg_r   <= err_s;
            if (wr_s) begin
                wr_addr_r <= wr_addr_s;
                wr_data_r <= wr_data_s;
            end else begin
                wr_addr_r <= wr_addr_r;
                wr_data_r <= wr_data_r;
            end
        end
    end

    // Only the data phase can take input words.
    assign bus.in_ready = (state_r == ST_DATA);
    assign bus.wr_en    = wr_en_r;
    assign bus.wr_addr  = wr_addr_r;
    assign bus.wr_data  = wr_data_r;
    assign line_done    = line_done_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign err_cfg      = err_cfg_r;

endmodule
